// File: rtl/mvm_uart_host.sv
// rtl/mvm_uart_host.sv - host-side UART link: serializes one K/X packet, collects R results
// One request then one response per transaction; the receiver free-runs but only stores in RECV.
module mvm_uart_host #(
    parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
    parameter int BITS_PER_WORD    = 8,
    parameter int PACKET_SIZE_TX   = BITS_PER_WORD + 5,
    parameter int W_Y_OUT          = 32,
    parameter int R                = 8,
    parameter int C                = 8,
    parameter int W_X              = 4,
    parameter int W_K              = 3,
    localparam int W_BUS_KX        = R * C * W_K + C * W_X,
    localparam int W_BUS_Y         = R * W_Y_OUT
) (
    input  logic                clk,
    input  logic                rstn,
    output logic                s_axis_kx_tready,
    input  logic                s_axis_kx_tvalid,
    input  logic [W_BUS_KX-1:0] s_axis_kx_tdata,
    input  logic                m_axis_y_tready,
    output logic                m_axis_y_tvalid,
    output logic [W_BUS_Y-1:0]  m_axis_y_tdata,
    output logic                tx,
    input  logic                rx,
    output logic                frame_err
);
    localparam int N_TX    = (W_BUS_KX + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int N_RX    = W_BUS_Y / BITS_PER_WORD;
    localparam int TXBUF_W = N_TX * BITS_PER_WORD;
    localparam int CNT_W   = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int TXB_W   = $clog2(PACKET_SIZE_TX + 1);
    localparam int TXN_W   = $clog2(N_TX + 1);
    localparam int RXB_W   = $clog2(BITS_PER_WORD + 1);
    localparam int RXN_W   = $clog2(N_RX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [TXB_W-1:0] TXB_LAST = TXB_W'(PACKET_SIZE_TX - 1);
    localparam logic [TXB_W-1:0] TXB_DATA = TXB_W'(BITS_PER_WORD);
    localparam logic [TXN_W-1:0] TXN_LAST = TXN_W'(N_TX - 1);
    localparam logic [RXB_W-1:0] RXB_LAST = RXB_W'(BITS_PER_WORD - 1);
    localparam logic [RXN_W-1:0] RXN_LAST = RXN_W'(N_RX - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV, S_OUT} state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    state_t                 state_q, state_d;
    logic                   kx_tready_q, kx_tready_d;
    logic [TXBUF_W-1:0]     kx_buf_q, kx_buf_d;
    logic                   tx_q, tx_d;
    logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
    logic [TXB_W-1:0]       tx_bit_q, tx_bit_d;
    logic [TXN_W-1:0]       tx_byte_q, tx_byte_d;
    logic                   rx_s1_q, rx_s1_d;
    logic                   rx_s2_q, rx_s2_d;
    logic                   rx_s3_q, rx_s3_d;
    rx_state_t              rx_state_q, rx_state_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [RXB_W-1:0]       rx_bit_q, rx_bit_d;
    logic [BITS_PER_WORD-1:0] rx_shift_q, rx_shift_d;
    logic [RXN_W-1:0]       rx_byte_q, rx_byte_d;
    logic                   y_tvalid_q, y_tvalid_d;
    logic [W_BUS_Y-1:0]     y_tdata_q, y_tdata_d;
    logic                   frame_err_q, frame_err_d;
    logic                   byte_done;

    always_comb begin
        state_d     = state_q;
        kx_buf_d    = kx_buf_q;
        tx_d        = tx_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_byte_d   = tx_byte_q;
        rx_s1_d     = rx;
        rx_s2_d     = rx_s1_q;
        rx_s3_d     = rx_s2_q;
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        y_tvalid_d  = y_tvalid_q;
        y_tdata_d   = y_tdata_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;

        // Receiver: falling edge arms, start re-checked at half a bit, then mid-bit sampling.
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s2_q && rx_s3_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[BITS_PER_WORD-1:1]};
                    if (rx_bit_q == RXB_LAST) rx_state_d = RX_STOP;
                    else                      rx_bit_d   = rx_bit_q + RXB_W'(1);
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        byte_done  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_WAIT;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_WAIT: begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase

        case (state_q)
            S_IDLE: begin
                if (kx_tready_q && s_axis_kx_tvalid) begin
                    state_d                = S_SEND;
                    kx_buf_d               = '0;
                    kx_buf_d[W_BUS_KX-1:0] = s_axis_kx_tdata;
                    tx_d                   = 1'b0;
                    tx_cnt_d               = '0;
                    tx_bit_d               = '0;
                    tx_byte_d              = '0;
                end
            end
            S_SEND: begin
                // The buffer shifts one bit per data bit, so bit 0 is always the next to send.
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == TXB_LAST) begin
                        tx_bit_d = '0;
                        if (tx_byte_q == TXN_LAST) begin
                            state_d   = S_RECV;
                            rx_byte_d = '0;
                        end else begin
                            tx_byte_d = tx_byte_q + TXN_W'(1);
                            tx_d      = 1'b0;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + TXB_W'(1);
                        if (tx_bit_q < TXB_DATA) begin
                            tx_d     = kx_buf_q[0];
                            kx_buf_d = kx_buf_q >> 1;
                        end else begin
                            tx_d = 1'b1;
                        end
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            S_RECV: begin
                if (byte_done) begin
                    y_tdata_d = {rx_shift_q, y_tdata_q[W_BUS_Y-1:BITS_PER_WORD]};
                    if (rx_byte_q == RXN_LAST) begin
                        state_d    = S_OUT;
                        y_tvalid_d = 1'b1;
                        rx_byte_d  = '0;
                    end else begin
                        rx_byte_d = rx_byte_q + RXN_W'(1);
                    end
                end
            end
            S_OUT: begin
                if (m_axis_y_tready) begin
                    state_d    = S_IDLE;
                    y_tvalid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        kx_tready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            kx_tready_q <= 1'b0;
            kx_buf_q    <= '0;
            tx_q        <= 1'b1;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_byte_q   <= '0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            y_tvalid_q  <= 1'b0;
            y_tdata_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kx_tready_q <= kx_tready_d;
            kx_buf_q    <= kx_buf_d;
            tx_q        <= tx_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_byte_q   <= tx_byte_d;
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            rx_s3_q     <= rx_s3_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            y_tvalid_q  <= y_tvalid_d;
            y_tdata_q   <= y_tdata_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign s_axis_kx_tready = kx_tready_q;
    assign m_axis_y_tvalid  = y_tvalid_q;
    assign m_axis_y_tdata   = y_tdata_q;
    assign tx               = tx_q;
    assign frame_err        = frame_err_q;

endmodule

// File: tb/tb_mvm_uart_host.sv
// tb/tb_mvm_uart_host.sv - scoreboard bench for mvm_uart_host (R=C=2, W_X=W_K=4, 4 clocks per bit)
module tb_mvm_uart_host;
    localparam int FRAME = 52;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        s_tready, s_tvalid;
    logic [23:0] s_tdata;
    logic        y_tready, y_tvalid;
    logic [63:0] y_tdata;
    logic        tx, rx, frame_err;

    mvm_uart_host #(
        .CLOCKS_PER_PULSE(4), .R(2), .C(2), .W_X(4), .W_K(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_kx_tready(s_tready), .s_axis_kx_tvalid(s_tvalid), .s_axis_kx_tdata(s_tdata),
        .m_axis_y_tready(y_tready), .m_axis_y_tvalid(y_tvalid), .m_axis_y_tdata(y_tdata),
        .tx(tx), .rx(rx), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         start;
    } tx_exp_t;

    tx_exp_t     tx_q[$];
    logic [63:0] y_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          fe_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred or bound expired, required otherwise", name);
    endtask

    // tx monitor: one frame = 52 samples; start, 8 data bits of 4 cycles, 16 stop cycles.
    initial begin : tx_mon
        logic [63:0] s, w;
        tx_exp_t     e;
        bit          have, ab;
        int          start;
        forever begin
            @(negedge clk);
            if (rstn && tx === 1'b0) begin
                have = (tx_q.size() > 0);
                if (have) e = tx_q.pop_front();
                else fail("tx_unexpected_frame");
                start = cyc;
                s = '0;
                s[0] = tx;
                ab = 1'b0;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    s[k] = tx;
                    if (!rstn) ab = 1'b1;
                end
                if (have) begin
                    check("tx_frame_start_cycle", 64'(start), 64'(e.start));
                    if (!ab) begin
                        w = '0;
                        for (int i = 0; i < 8; i++)
                            for (int j = 0; j < 4; j++) w[4 + 4*i + j] = e.data[i];
                        for (int k = 36; k < FRAME; k++) w[k] = 1'b1;
                        check("tx_frame_waveform", s, w);
                    end
                end
            end
        end
    end

    initial begin : y_mon
        forever begin
            @(negedge clk);
            if (rstn && y_tvalid && y_tready) begin
                if (y_q.size() == 0) fail("y_unexpected_result");
                else check("y_tdata", y_tdata, y_q.pop_front());
            end
        end
    end

    initial begin : fe_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) begin
                fe_cnt++;
                if (prev) fail("frame_err_pulse_width");
            end
            prev = frame_err;
        end
    end

    task automatic send_kx(input logic [23:0] d, input int n_frames, output int hs);
        bit got;
        got = 1'b0;
        hs = 0;
        @(posedge clk); #1;
        s_tvalid = 1'b1;
        s_tdata  = d;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (s_tready) begin
                got = 1'b1;
                hs = cyc + 1;
                for (int i = 0; i < n_frames; i++) begin
                    tx_exp_t e;
                    e.data  = d[8*i +: 8];
                    e.start = hs + FRAME * i;
                    tx_q.push_back(e);
                end
            end
        end
        if (!got) fail("kx_handshake_timeout");
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        check("kx_tready_low_after_hs", 64'(s_tready), 64'd0);
    endtask

    task automatic rx_level(input logic v, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx = v;
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        rx_level(1'b0, 4);
        for (int i = 0; i < 8; i++) rx_level(b[i], 4);
        rx_level(stop, 4);
        rx_level(1'b1, stop ? 2 : 8);
    endtask

    task automatic wait_tx_done(input int hs);
        for (int t = 0; t < 400 && cyc < hs + 3 * FRAME + 2; t++) @(posedge clk);
    endtask

    task automatic wait_tvalid();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (y_tvalid) got = 1'b1;
        end
        if (!got) fail("y_tvalid_timeout");
    endtask

    initial begin : main
        int hs, bad;
        logic [63:0] snap;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        y_tready = 1'b0;
        rx       = 1'b1;
        #1 rstn = 1'b0;
        #2;
        check("reset_kx_tready", 64'(s_tready), 64'd0);
        check("reset_y_tvalid", 64'(y_tvalid), 64'd0);
        check("reset_y_tdata", y_tdata, 64'd0);
        check("reset_tx", 64'(tx), 64'd1);
        check("reset_frame_err", 64'(frame_err), 64'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("kx_tready_before_first_edge", 64'(s_tready), 64'd0);
        @(negedge clk);
        check("kx_tready_after_release", 64'(s_tready), 64'd1);

        // Transaction 1: basic packet, result held back for 100 cycles
        send_kx(24'hA53C81, 3, hs);
        wait_tx_done(hs);
        check("tx_queue_drained_t1", 64'(tx_q.size()), 64'd0);
        y_q.push_back(64'h0807060504030201);
        for (int i = 1; i <= 8; i++) rx_byte(8'(i), 1'b1);
        wait_tvalid();
        snap = y_tdata;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!y_tvalid || y_tdata !== snap || s_tready) bad++;
        end
        check("y_hold_stable", 64'(bad), 64'd0);
        @(posedge clk); #1;
        y_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("y_tvalid_cleared", 64'(y_tvalid), 64'd0);
        check("y_tdata_retained", y_tdata, 64'h0807060504030201);
        check("kx_tready_after_result", 64'(s_tready), 64'd1);

        // Byte while IDLE must be ignored
        rx_byte(8'hEE, 1'b1);

        // Transaction 2: glitch and a framing error inside RECV
        send_kx(24'h00FF12, 3, hs);
        wait_tx_done(hs);
        y_q.push_back(64'h8877665544332211);
        rx_level(1'b0, 1);
        rx_level(1'b1, 12);
        check("frame_err_after_glitch", 64'(fe_cnt), 64'd0);
        rx_byte(8'h55, 1'b0);
        check("frame_err_after_bad_stop", 64'(fe_cnt), 64'd1);
        for (int i = 1; i <= 8; i++) rx_byte(8'(8'h11 * i), 1'b1);
        wait_tvalid();
        repeat (3) @(negedge clk);
        check("y_queue_drained_t2", 64'(y_q.size()), 64'd0);

        // Transaction 3: reset during the start bit of byte 1
        send_kx(24'h123456, 2, hs);
        while (cyc < hs + FRAME + 1) begin
            @(posedge clk); #2;
        end
        check("tx_low_before_reset", 64'(tx), 64'd0);
        rstn = 1'b0;
        #1;
        check("tx_high_in_reset", 64'(tx), 64'd1);
        check("kx_tready_in_reset", 64'(s_tready), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("kx_tready_low_after_reset", 64'(s_tready), 64'd0);
        @(negedge clk);
        check("kx_tready_high_after_reset", 64'(s_tready), 64'd1);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (y_tvalid || !tx) bad++;
        end
        check("quiet_after_reset", 64'(bad), 64'd0);
        check("tx_queue_drained_t3", 64'(tx_q.size()), 64'd0);

        // Transaction 4: normal operation after reset
        send_kx(24'h0000C3, 3, hs);
        wait_tx_done(hs);
        y_q.push_back(64'hA7A6A5A4A3A2A1A0);
        for (int i = 0; i < 8; i++) rx_byte(8'(8'hA0 + i), 1'b1);
        wait_tvalid();
        repeat (3) @(negedge clk);
        check("y_queue_drained_t4", 64'(y_q.size()), 64'd0);
        check("tx_queue_drained_t4", 64'(tx_q.size()), 64'd0);
        check("frame_err_total", 64'(fe_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500_000;
        fail("global_timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
